// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states and
// the predicate that marks ops which occupy the unit for several cycles.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MFHI  = 3'd4,
    MDU_MFLO  = 3'd5,
    MDU_MTHI  = 3'd6,
    MDU_MTLO  = 3'd7
  } mdu_op_e;

  typedef enum logic {
    MDU_IDLE = 1'b0,
    MDU_RUN  = 1'b1
  } mdu_state_e;

  // mult/multu/div/divu are the only ops that hold the unit busy.
  function automatic logic is_md_busy_op(input logic [2:0] op);
    return (op[2] == 1'b0);
  endfunction

endpackage

// File: rtl/md_unit.sv
// E-stage multiply/divide unit owning HI/LO. The result is computed on the
// start edge into pending registers and committed after the programmed
// number of busy cycles, so the pipeline sees a fixed, op-dependent latency.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no operation in flight; accepts mult/div and mthi/mtlo
// RUN   | mult/div in flight; counter counts down to commit, new starts ignored
module md_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);

  mdu_state_e state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic [31:0]   hi_q, lo_q;
  logic [31:0]   pending_hi_q, pending_lo_q;
  logic          pending_wr_q;

  logic launch, commit, wr_hi, wr_lo;

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, div_s, quo_mag, rem_mag;
  logic [31:0] div_u, quo_u, rem_u;
  logic [31:0] res_hi, res_lo;
  logic        res_wr;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= MDU_IDLE;
    else       state_q <= state_d;
  end

  // Next-state: launch a long op from IDLE, return when the counter expires.
  always_comb begin
    state_d = state_q;
    case (state_q)
      MDU_IDLE: if (start && is_md_busy_op(op)) state_d = MDU_RUN;
      MDU_RUN:  if (cnt_q == CW'(1))            state_d = MDU_IDLE;
      default:  state_d = MDU_IDLE;
    endcase
  end

  // Outputs and datapath strobes derived from the current state.
  always_comb begin
    busy     = (state_q == MDU_RUN);
    md_stall = busy | (start & is_md_busy_op(op));
    launch   = (state_q == MDU_IDLE) && start && is_md_busy_op(op);
    commit   = (state_q == MDU_RUN) && (cnt_q == CW'(1));
    wr_hi    = (state_q == MDU_IDLE) && start && (op == MDU_MTHI);
    wr_lo    = (state_q == MDU_IDLE) && start && (op == MDU_MTLO);
    md_out   = 32'd0;
    if (op == MDU_MFHI)      md_out = hi_q;
    else if (op == MDU_MFLO) md_out = lo_q;
  end

  // Arithmetic. Signed divide works on magnitudes so 0x80000000 / -1 wraps
  // to 0x80000000 rem 0 without a special case; a zero divisor is replaced
  // by 1 to keep the divider defined, and the result is simply not written.
  always_comb begin
    prod_s  = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u  = {32'd0, A} * {32'd0, B};
    a_mag   = A[31] ? (32'd0 - A) : A;
    b_mag   = B[31] ? (32'd0 - B) : B;
    div_s   = (b_mag == 32'd0) ? 32'd1 : b_mag;
    quo_mag = a_mag / div_s;
    rem_mag = a_mag % div_s;
    div_u   = (B == 32'd0) ? 32'd1 : B;
    quo_u   = A / div_u;
    rem_u   = A % div_u;
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_wr  = 1'b1;
    case (op)
      MDU_MULT:  begin res_hi = prod_s[63:32]; res_lo = prod_s[31:0]; end
      MDU_MULTU: begin res_hi = prod_u[63:32]; res_lo = prod_u[31:0]; end
      MDU_DIV: begin
        res_lo = (A[31] ^ B[31]) ? (32'd0 - quo_mag) : quo_mag;
        res_hi = A[31] ? (32'd0 - rem_mag) : rem_mag;
        res_wr = (B != 32'd0);
      end
      MDU_DIVU: begin
        res_lo = quo_u;
        res_hi = rem_u;
        res_wr = (B != 32'd0);
      end
      default: res_wr = 1'b0;
    endcase
  end

  // Counter, pending result and architectural HI/LO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      pending_hi_q <= 32'd0;
      pending_lo_q <= 32'd0;
      pending_wr_q <= 1'b0;
      hi_q         <= 32'd0;
      lo_q         <= 32'd0;
    end else begin
      if (launch) begin
        cnt_q        <= (op[1] == 1'b0) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
        pending_hi_q <= res_hi;
        pending_lo_q <= res_lo;
        pending_wr_q <= res_wr;
      end else if (state_q == MDU_RUN) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (commit && pending_wr_q) begin
        hi_q <= pending_hi_q;
        lo_q <= pending_lo_q;
      end
      if (wr_hi) hi_q <= A;
      if (wr_lo) lo_q <= A;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed scenarios plus random ops,
// compared against a 64-bit arithmetic reference model of HI/LO.
module tb_md_unit;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk, reset, start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, md_stall;
  logic [31:0] HI, LO, md_out;

  int n_assert = 0;
  int n_fail   = 0;
  logic [31:0] m_hi, m_lo;

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .A(A), .B(B),
    .busy(busy), .md_stall(md_stall), .HI(HI), .LO(LO), .md_out(md_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: full-width arithmetic on sign/zero-extended operands.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] eh, output logic [31:0] el, output bit wr);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, pu, qu, ru;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    eh = m_hi; el = m_lo; wr = 1'b0;
    case (o)
      3'd0: begin p = sa * sb; eh = p[63:32]; el = p[31:0]; wr = 1'b1; end
      3'd1: begin pu = ua * ub; eh = pu[63:32]; el = pu[31:0]; wr = 1'b1; end
      3'd2: if (b != 0) begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; wr = 1'b1; end
      3'd3: if (b != 0) begin qu = ua / ub; ru = ua % ub; el = qu[31:0]; eh = ru[31:0]; wr = 1'b1; end
      3'd6: begin eh = a; wr = 1'b1; end
      3'd7: begin el = a; wr = 1'b1; end
      default: ;
    endcase
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] eh, el;
    bit wr;
    int n;
    bit long_op;
    long_op = (o <= 3'd3);
    model(o, a, b, eh, el, wr);
    start = 1'b1; op = o; A = a; B = b;
    #1;
    chk("md_stall_start", {31'd0, md_stall}, {31'd0, long_op});
    if (o == 3'd4)      chk("md_out_mfhi", md_out, m_hi);
    else if (o == 3'd5) chk("md_out_mflo", md_out, m_lo);
    else                chk("md_out_zero", md_out, 32'd0);
    step();
    start = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
    if (long_op) begin
      n = 0;
      while (busy && n < 100) begin
        n++;
        step();
      end
      chk("busy_cycles", 32'(n), (o[1] ? 32'(DC) : 32'(MC)));
    end
    if (wr) begin m_hi = eh; m_lo = el; end
    chk("busy_idle", {31'd0, busy}, 32'd0);
    chk("hi", HI, m_hi);
    chk("lo", LO, m_lo);
  endtask

  initial begin
    int n;
    logic [31:0] ra, rb;
    logic [2:0]  ro;
    reset = 1'b1; start = 1'b0; op = 3'd4; A = 32'd0; B = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    step(); step();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_hi", HI, 32'd0);
    chk("rst_lo", LO, 32'd0);
    chk("rst_md_out", md_out, 32'd0);
    reset = 1'b0;
    step();
    chk("post_rst_stall", {31'd0, md_stall}, 32'd0);

    run_op(3'd0, 32'hFFFFFFFD, 32'd5);
    chk("plan1_hi", HI, 32'hFFFFFFFF);
    chk("plan1_lo", LO, 32'hFFFFFFF1);
    run_op(3'd1, 32'hFFFFFFFF, 32'd2);
    chk("plan2_hi", HI, 32'h00000001);
    chk("plan2_lo", LO, 32'hFFFFFFFE);
    run_op(3'd2, 32'hFFFFFFF9, 32'd2);
    chk("plan2_div_lo", LO, 32'hFFFFFFFD);
    chk("plan2_div_hi", HI, 32'hFFFFFFFF);

    run_op(3'd6, 32'h12345678, 32'd0);
    chk("plan3_mthi", HI, 32'h12345678);
    run_op(3'd5, 32'd0, 32'd0);
    run_op(3'd2, 32'h00001234, 32'd0);
    run_op(3'd3, 32'hCAFEF00D, 32'd0);

    // Starts issued while busy must be ignored.
    run_op(3'd7, 32'h55AA55AA, 32'd0);
    start = 1'b1; op = 3'd0; A = 32'h00010003; B = 32'hFFFFFFFE;
    step();
    n = 0;
    while (busy && n < 100) begin
      start = 1'b0;
      if (n == 1) begin start = 1'b1; op = 3'd7; A = 32'hDEADBEEF; end
      if (n == 2) begin start = 1'b1; op = 3'd2; A = 32'd100; B = 32'd7; end
      if (n == 3) begin
        start = 1'b1; op = 3'd4; #1;
        chk("busy_md_out", md_out, m_hi);
        chk("busy_stall", {31'd0, md_stall}, 32'd1);
      end
      n++;
      step();
    end
    start = 1'b0;
    chk("ign_busy_cycles", 32'(n), 32'(MC));
    m_hi = 32'hFFFFFFFF; m_lo = 32'hFFFDFFFA;  // 0x00010003 * -2
    chk("ign_hi", HI, m_hi);
    chk("ign_lo", LO, m_lo);

    // Asynchronous reset in the middle of a divu.
    start = 1'b1; op = 3'd3; A = 32'hFFFF0000; B = 32'd3;
    step();
    start = 1'b0;
    step(); step(); step();
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_hi", HI, 32'd0);
    chk("async_rst_lo", LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    step();
    reset = 1'b0;
    step();
    run_op(3'd0, 32'd7, 32'd9);

    run_op(3'd2, 32'h80000000, 32'hFFFFFFFF);
    chk("plan6_lo", LO, 32'h80000000);
    chk("plan6_hi", HI, 32'h00000000);

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 9))
        0: rb = 32'd0;
        1: rb = 32'hFFFFFFFF;
        default: rb = 32'($urandom);
      endcase
      run_op(ro, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
Multiply/divide unit in the E stage of the 5-stage MIPS pipeline. Owns the HI/LO registers and executes mult, multu, div, divu, mfhi, mflo, mthi and mtlo.
- Produces the busy indication that the hazard/stall controller consumes. It is the producer side of the stall handshake, where the stall controller is the consumer.
- The stall controller freezes D when a D-stage MD instruction meets a busy or starting MDU.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)

Ports:
clk  input  1  pipeline clock, rising-edge active
reset  input  1  asynchronous, active-high; clears all state
start  input  1  E-stage instruction valid for MDU, one-cycle qualifier
op  input  3  operation code (package encodings)
A  input  32  rs operand (E stage, after forwarding)
B  input  32  rt operand (E stage, after forwarding)
busy  output  1  registered; high while a mult/div is in flight
md_stall  output  1  combinational; busy | (start & op is mult/multu/div/divu); to stall controller
HI  output  32  architectural HI
LO  output  32  architectural LO
md_out  output  32  combinational; HI for MFHI, LO for MFLO, else 0

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset values: busy=0, HI=0, LO=0, counter=0, pending result regs=0. md_out follows HI/LO.
- States: IDLE (busy=0) and RUN (busy=1). A down-counter tracks remaining cycles; its width is clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- IDLE, start with mult/multu/div/divu:
  - On that edge, compute the result combinationally from A/B into pending_hi/pending_lo.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- RUN: the counter decrements each edge. On the edge where the counter reaches 0, commit pending_hi/pending_lo to HI/LO and set busy=0.
  - busy is high for exactly N consecutive cycles after the start cycle.
  - HI/LO hold new values in the cycle busy first reads 0.
- Arithmetic:
  - mult: signed 32x32->64, HI=[63:32], LO=[31:0]. multu: unsigned.
  - div/divu: LO=quotient, HI=remainder. Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - div 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0.
  - Divide by zero (B==0): operation still occupies DIV_CYCLES busy cycles; HI/LO unchanged at commit.
- mthi/mtlo with start in IDLE: HI (or LO) <= A on that edge; no busy.
- mfhi/mflo: combinational read of current HI/LO via md_out; no state change.
- Boundary conditions:
  - start while busy=1, any op: ignored. The stall controller guarantees this does not occur. If it does occur, busy, counter, HI and LO are unaffected and md_out still reads.
  - start=0: op/A/B are ignored.
  - Reset asserted mid-RUN: immediate return to IDLE. HI=LO=0 and the pending result is discarded.
- Latency: mthi/mtlo take 1 edge. Mult takes MULT_CYCLES+1 edges to HI/LO update, counting the start edge. Div takes DIV_CYCLES+1.

Decomposition:
- Shared package mdu_pkg holds the op encodings:
  - MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3
  - MDU_MFHI=4, MDU_MFLO=5, MDU_MTHI=6, MDU_MTLO=7
  - predicate is_md_busy_op (ops 0-3)
- The instruction decoder and the stall controller import mdu_pkg.
- No sub-module. Arithmetic uses inline behavioural operators; the RUN counter is a local register.

Test Plan:
1. Reset, then mult with A=0xFFFFFFFD (-3), B=5 -> md_stall=1 on the start cycle; busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
2. multu with A=0xFFFFFFFF, B=2 -> after 5 busy cycles, HI=0x00000001, LO=0xFFFFFFFE. Then div A=0xFFFFFFF9 (-7), B=2 -> busy for 10 cycles; LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. mthi A=0x12345678, then mflo -> HI=0x12345678 next cycle, no busy; md_out=LO unchanged. div with B=0 -> busy for 10 cycles; HI and LO unchanged.
4. During a mult RUN, issue start with mtlo A=0xDEADBEEF and start with div -> both ignored. busy drops on schedule and LO equals the mult result.
5. Start divu, assert reset at busy cycle 4 -> busy=0, HI=0, LO=0 immediately (asynchronously). The next mult after reset completes normally.
6. Signed edge case div A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
